muldiv_seq: RTL

Iterative multiply/divide sequencer for the RISC-V pipeline's execute stage, covering unsigned M-extension ops (MUL, MULHU, DIVU, REMU). It sequences one internal `alu` instance through 32 add or subtract steps, using the ALU's carry flag for the carry-in/borrow decision. It presents a start/busy/done handshake so the hazard logic can stall the pipeline while an operation is in flight.

---
 rtl/muldiv_pkg.sv | 35 +++
 rtl/alu.sv | 28 ++
 rtl/muldiv_seq.sv | 135 +++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings and sizing for the iterative multiply/divide sequencer.
package muldiv_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned ITER  = 32;
    localparam int unsigned CNT_W = $clog2(ITER);

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_MULHU = 2'b01,
        OP_DIVU  = 2'b10,
        OP_REMU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    function automatic logic is_div_op(input op_e o);
        return (o == OP_DIVU) || (o == OP_REMU);
    endfunction

    // MULHU and REMU return the upper/remainder register, the others the lower/quotient one.
    function automatic logic is_hi_op(input op_e o);
        return (o == OP_MULHU) || (o == OP_REMU);
    endfunction

endpackage

// File: rtl/alu.sv
// Shared integer ALU; carry_c is the adder carry-out (1 = no borrow on subtract).
module alu
    import muldiv_pkg::*;
(
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic [2:0]      alu_control,
    output logic [XLEN-1:0] result_c,
    output logic            carry_c
);

    logic            sub;
    logic [XLEN:0]   sum;

    always_comb begin
        sub      = (alu_control == ALU_SUB);
        sum      = {1'b0, src_a} + {1'b0, (sub ? ~src_b : src_b)} + (XLEN + 1)'(sub);
        result_c = sum[XLEN-1:0];
        carry_c  = 1'b0;
        case (alu_control)
            ALU_ADD, ALU_SUB: carry_c  = sum[XLEN];
            ALU_AND:          result_c = src_a & src_b;
            ALU_OR:           result_c = src_a | src_b;
            default:          ;
        endcase
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU sequencer: one ALU step per cycle for 32 cycles,
// start/busy/done handshake, synchronous flush abort.
module muldiv_seq
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic [XLEN-1:0]   b_q, b_d;
    op_e               op_q, op_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              div_mode;
    logic [XLEN-1:0]   shl_r;
    logic [XLEN-1:0]   alu_a;
    logic [XLEN-1:0]   alu_res;
    logic [2:0]        alu_ctl;
    logic              alu_c;
    logic              take;
    logic              mul_c;
    logic [XLEN-1:0]   mul_h;

    // Divide works on R already shifted left with Q's top bit; multiply adds into hi directly.
    assign div_mode = is_div_op(op_q);
    assign shl_r    = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
    assign alu_a    = div_mode ? shl_r : hi_q;
    assign alu_ctl  = div_mode ? ALU_SUB : ALU_ADD;

    alu u_alu (
        .src_a       (alu_a),
        .src_b       (b_q),
        .alu_control (alu_ctl),
        .result_c    (alu_res),
        .carry_c     (alu_c)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        take     = 1'b0;
        mul_c    = 1'b0;
        mul_h    = hi_q;

        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    hi_d    = '0;
                    lo_d    = a;
                    b_d     = b;
                    op_d    = op_e'(op);
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (div_mode) begin
                        // Shifted-out R bit set means R' >= 2^32 > b, so subtract regardless of C.
                        take = hi_q[XLEN-1] | alu_c;
                        hi_d = take ? alu_res : shl_r;
                        lo_d = {lo_q[XLEN-2:0], take};
                    end else begin
                        if (lo_q[0]) begin
                            mul_c = alu_c;
                            mul_h = alu_res;
                        end
                        hi_d = {mul_c, mul_h[XLEN-1:1]};
                        lo_d = {mul_h[0], lo_q[XLEN-1:1]};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(ITER - 1)) begin
                        state_d  = S_DONE;
                        result_d = is_hi_op(op_q) ? hi_d : lo_d;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            op_q     <= OP_MUL;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            b_q      <= b_d;
            op_q     <= op_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule
